// File: rtl/line_echo.sv
// Line-buffered echo between the two byte streams of a USB CDC core: bytes are
// collected until a terminator, a full buffer or an idle timeout, then replayed.
module line_echo #(
  parameter int          DEPTH      = 64,
  parameter logic [7:0]  TERMINATOR = 8'h0D,
  parameter bit          UPPERCASE  = 1'b1,
  parameter logic [15:0] TIMEOUT    = 16'd48000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               out_data_i,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  output logic [7:0]               in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  output logic [$clog2(DEPTH):0]   line_len_o,
  output logic                     busy_o
);

  localparam int                AW          = $clog2(DEPTH);
  localparam int                LW          = AW + 1;
  localparam logic [LW-1:0]     LEN_ONE     = LW'(1);
  localparam logic [LW-1:0]     LEN_NEAR    = LW'(DEPTH - 1);
  localparam logic [15:0]       IDLE_LAST   = TIMEOUT - 16'd1;
  localparam bit                TIMEOUT_ON  = (TIMEOUT != 16'd0);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   line_len;
  logic [15:0]     idle_cnt;
  logic [7:0]      buffer [DEPTH];

  logic            byte_acc;
  logic            out_acc;
  logic            idle_expire;
  logic            line_closes;
  logic [7:0]      rd_byte;

  function automatic logic [7:0] convert(input logic [7:0] b);
    if (UPPERCASE && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
    return b;
  endfunction

  assign byte_acc    = out_valid_i && (state == FILL);
  assign out_acc     = in_ready_i && (state == DRAIN);

  // Expiry is an edge event: the counter sits one below TIMEOUT and this edge
  // would make it reach TIMEOUT, so the partial line is released on this edge.
  assign idle_expire = TIMEOUT_ON && (line_len != '0) && (idle_cnt == IDLE_LAST);

  // A byte arriving on the expiry edge still joins the line before it drains.
  assign line_closes = (out_data_i == TERMINATOR) || (line_len == LEN_NEAR) || idle_expire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      line_len <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (byte_acc) begin
            wr_ptr   <= wr_ptr + AW'(1);
            line_len <= line_len + LEN_ONE;
            idle_cnt <= '0;
            if (line_closes) state <= DRAIN;
          end else if (idle_expire) begin
            idle_cnt <= '0;
            state    <= DRAIN;
          end else if (TIMEOUT_ON && (line_len != '0)) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (out_acc) begin
            if (line_len == LEN_ONE) begin
              state    <= FILL;
              wr_ptr   <= '0;
              rd_ptr   <= '0;
              line_len <= '0;
              idle_cnt <= '0;
            end else begin
              rd_ptr   <= rd_ptr + AW'(1);
              line_len <= line_len - LEN_ONE;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // NOTE: the line storage has no reset; line_len decides which entries are
  // meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk_i) begin
    if (byte_acc) buffer[wr_ptr] <= out_data_i;
  end

  assign rd_byte = buffer[rd_ptr];

  // NOTE: default assignment first so no path leaves in_data_o unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    in_data_o = 8'h00;
    if (state == DRAIN) in_data_o = convert(rd_byte);
  end

  assign out_ready_o = (state == FILL);
  assign in_valid_o  = (state == DRAIN);
  assign busy_o      = (state == DRAIN);
  assign line_len_o  = line_len;

endmodule

// File: tb/tb_line_echo.sv
// Directed bench for line_echo: a default instance (DEPTH 64, uppercase) and a
// small one (DEPTH 4, no case conversion, TIMEOUT 10) share clock and reset.
module tb_line_echo;

  logic        clk;
  logic        rst;
  logic [7:0]  od   [2];
  logic        ov   [2];
  logic        ory  [2];
  logic [7:0]  idt  [2];
  logic        ivl  [2];
  logic        ir   [2];
  logic        busy [2];
  logic [6:0]  len0;
  logic [2:0]  len1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  line_echo u_big (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(od[0]), .out_valid_i(ov[0]), .out_ready_o(ory[0]),
    .in_data_o(idt[0]), .in_valid_o(ivl[0]), .in_ready_i(ir[0]),
    .line_len_o(len0), .busy_o(busy[0])
  );

  line_echo #(.DEPTH(4), .TERMINATOR(8'h0D), .UPPERCASE(1'b0), .TIMEOUT(16'd10)) u_small (
    .clk_i(clk), .rst_i(rst),
    .out_data_i(od[1]), .out_valid_i(ov[1]), .out_ready_o(ory[1]),
    .in_data_o(idt[1]), .in_valid_o(ivl[1]), .in_ready_i(ir[1]),
    .line_len_o(len1), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_len(input int s);
    return (s == 0) ? 32'(len0) : 32'(len1);
  endfunction

  task automatic check_idle(input int s, input string tag);
    check({tag, "_ready"}, 32'(ory[s]), 32'd1);
    check({tag, "_valid"}, 32'(ivl[s]), 32'd0);
    check({tag, "_data"},  32'(idt[s]), 32'd0);
    check({tag, "_busy"},  32'(busy[s]), 32'd0);
    check({tag, "_len"},   get_len(s), 32'd0);
  endtask

  // Called at #1 after an edge; returns at #1 after the edge that took the byte.
  task automatic send_byte(input int s, input logic [7:0] b);
    int waited = 0;
    od[s] = b;
    ov[s] = 1'b1;
    while (!ory[s] && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ory[s]) check("send_ready_timeout", 32'(ory[s]), 32'd1);
    @(posedge clk); #1;
    ov[s] = 1'b0;
    od[s] = 8'h00;
  endtask

  task automatic send_seq(input int s);
    foreach (tx_q[i]) send_byte(s, tx_q[i]);
  endtask

  task automatic drain(input int s, input bit stall);
    int   k   = 0;
    int   cyc = 0;
    logic acc;
    while (k < rx_q.size() && cyc < 200) begin
      check($sformatf("drain%0d_valid_%0d", s, k), 32'(ivl[s]), 32'd1);
      check($sformatf("drain%0d_data_%0d", s, k), 32'(idt[s]), 32'(rx_q[k]));
      ir[s] = stall ? (cyc % 2 == 0) : 1'b1;
      acc   = ivl[s] & ir[s];
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    ir[s] = 1'b0;
    check($sformatf("drain%0d_count", s), 32'(k), 32'(rx_q.size()));
    check($sformatf("drain%0d_end_valid", s), 32'(ivl[s]), 32'd0);
    check($sformatf("drain%0d_end_busy", s), 32'(busy[s]), 32'd0);
    check($sformatf("drain%0d_end_len", s), get_len(s), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      od[i] = 8'h00; ov[i] = 1'b0; ir[i] = 1'b0;
    end
    #2;
    check_idle(0, "rst_big");
    check_idle(1, "rst_small");
    @(posedge clk); #1;
    rst = 1'b0;

    // "ab1\r" with uppercase conversion, output one clock after the terminator
    tx_q = '{8'h61, 8'h62, 8'h31};
    send_seq(0);
    check("basic_len3", get_len(0), 32'd3);
    check("basic_fill_busy", 32'(busy[0]), 32'd0);
    send_byte(0, 8'h0D);
    check("basic_latency_valid", 32'(ivl[0]), 32'd1);
    check("basic_drain_ready", 32'(ory[0]), 32'd0);
    check("basic_len4", get_len(0), 32'd4);
    rx_q = '{8'h41, 8'h42, 8'h31, 8'h0D};
    drain(0, 1'b0);

    // case boundaries: 60, 7B untouched, 7A converted
    tx_q = '{8'h60, 8'h7B, 8'h7A, 8'h41, 8'h0D};
    send_seq(0);
    rx_q = '{8'h60, 8'h7B, 8'h5A, 8'h41, 8'h0D};
    drain(0, 1'b0);

    // no conversion on the small instance
    tx_q = '{8'h7A, 8'h7B, 8'h0D};
    send_seq(1);
    rx_q = '{8'h7A, 8'h7B, 8'h0D};
    drain(1, 1'b0);

    // stalled drain: data must hold while in_ready_i is low
    tx_q = '{8'h78, 8'h79, 8'h7A, 8'h0D};
    send_seq(0);
    rx_q = '{8'h58, 8'h59, 8'h5A, 8'h0D};
    drain(0, 1'b1);

    // full buffer without terminator; fifth byte held off until the drain ends
    tx_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    send_seq(1);
    check("full_busy", 32'(busy[1]), 32'd1);
    check("full_len", get_len(1), 32'd4);
    od[1] = 8'h35;
    ov[1] = 1'b1;
    check("full_ready_low", 32'(ory[1]), 32'd0);
    rx_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    drain(1, 1'b0);
    @(posedge clk); #1;
    ov[1] = 1'b0;
    od[1] = 8'h00;
    check("full_fifth_len", get_len(1), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("full_fifth_timeout", 32'(busy[1]), 32'd1);
    rx_q = '{8'h35};
    drain(1, 1'b0);

    // exactly DEPTH bytes ending in the terminator drains once
    tx_q = '{8'h61, 8'h62, 8'h63, 8'h0D};
    send_seq(1);
    rx_q = '{8'h61, 8'h62, 8'h63, 8'h0D};
    drain(1, 1'b0);
    busy_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ivl[1]) busy_seen++; end
    check("exact_no_extra", 32'(busy_seen), 32'd0);

    // idle timeout: 2 bytes, drain exactly 10 idle clocks later
    tx_q = '{8'h70, 8'h71};
    send_seq(1);
    busy_seen = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (busy[1]) busy_seen++;
    end
    check("to_early", 32'(busy_seen), 32'd0);
    @(posedge clk); #1;
    check("to_enter", 32'(busy[1]), 32'd1);
    rx_q = '{8'h70, 8'h71};
    drain(1, 1'b0);
    busy_seen = 0;
    repeat (100) begin @(posedge clk); #1; if (busy[1]) busy_seen++; end
    check("to_empty_no_drain", 32'(busy_seen), 32'd0);

    // byte accepted on the expiry edge joins the drained line
    send_byte(1, 8'h41);
    repeat (9) begin @(posedge clk); #1; end
    check("expire_edge_still_fill", 32'(busy[1]), 32'd0);
    od[1] = 8'h42;
    ov[1] = 1'b1;
    @(posedge clk); #1;
    ov[1] = 1'b0;
    od[1] = 8'h00;
    check("expire_edge_busy", 32'(busy[1]), 32'd1);
    check("expire_edge_len", get_len(1), 32'd2);
    rx_q = '{8'h41, 8'h42};
    drain(1, 1'b0);

    // reset in the middle of a drain discards the rest of the line
    tx_q = '{8'h61, 8'h62, 8'h0D};
    send_seq(0);
    check("rstmid_first", 32'(idt[0]), 32'h41);
    ir[0] = 1'b1;
    @(posedge clk); #1;
    ir[0] = 1'b0;
    check("rstmid_busy", 32'(busy[0]), 32'd1);
    check("rstmid_len", get_len(0), 32'd2);
    rst = 1'b1;
    #1;
    check_idle(0, "rstmid");
    @(posedge clk); #1;
    rst = 1'b0;
    ir[0] = 1'b1;
    busy_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ivl[0]) busy_seen++; end
    ir[0] = 1'b0;
    check("rstmid_no_output", 32'(busy_seen), 32'd0);
    tx_q = '{8'h31, 8'h0D};
    send_seq(0);
    rx_q = '{8'h31, 8'h0D};
    drain(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/line_echo.md
LINE_ECHO -- requirements
Module: line_echo

Interface
- Parameters (name, default, meaning):
REQ-001 SHALL provide DEPTH, 64, line buffer size in bytes; power of 2, range 4..256.
REQ-002 SHALL provide TERMINATOR, 8'h0D, byte value that closes a line.
REQ-003 SHALL provide UPPERCASE, 1, when 1 convert 'a'..'z' to 'A'..'Z' on output.
REQ-004 SHALL provide TIMEOUT, 16'd48000, idle clocks before a partial line is released; 0 disables timeout.
- Ports (name, direction, width, meaning):
REQ-005 SHALL provide clk_i, input, 1, sole clock, 48 MHz domain of usb_cdc clk_i.
REQ-006 SHALL provide rst_i, input, 1, reset; reset is asynchronous and active-high.
REQ-007 SHALL provide out_data_i, input, 8, byte from usb_cdc out_data_o.
REQ-008 SHALL provide out_valid_i, input, 1, byte valid from usb_cdc out_valid_o.
REQ-009 SHALL provide out_ready_o, output, 1, byte accept to usb_cdc out_ready_i.
REQ-010 SHALL provide in_data_o, output, 8, byte to usb_cdc in_data_i.
REQ-011 SHALL provide in_valid_o, output, 1, byte valid to usb_cdc in_valid_i.
REQ-012 SHALL provide in_ready_i, input, 1, accept from usb_cdc in_ready_o.
REQ-013 SHALL provide line_len_o, output, $clog2(DEPTH)+1, bytes held in current line.
REQ-014 SHALL provide busy_o, output, 1, high in DRAIN state.

Function
REQ-015 SHALL implement two states, FILL and DRAIN; out_ready_o = (state==FILL), in_valid_o = busy_o = (state==DRAIN).
REQ-016 SHALL treat a transfer on either side as valid&ready high at a rising clk_i edge; no other cycle moves data.
REQ-017 In FILL, an accepted byte SHALL be written to buffer[wr_ptr], wr_ptr and line_len_o incremented the same edge.
REQ-018 FILL->DRAIN SHALL occur on the edge that accepts a byte equal to TERMINATOR or the byte making line_len_o == DEPTH; that byte is stored and emitted.
REQ-019 Idle counter SHALL reset to 0 on every accepted byte and count up otherwise while line_len_o>0 in FILL; reaching TIMEOUT SHALL move to DRAIN next edge.
REQ-020 Timeout SHALL never fire with line_len_o==0 or TIMEOUT==0.
REQ-021 If a byte is accepted on the edge the idle counter would expire, the byte SHALL be stored and included in the drained line.
REQ-022 in_valid_o SHALL be high the first cycle after the FILL->DRAIN edge (latency 1 clock from closing byte to first output).
REQ-023 In DRAIN, in_data_o SHALL be buffer[rd_ptr] after optional case conversion (UPPERCASE=1 and 8'h61..8'h7A: subtract 8'h20; all else unchanged), combinational from registered state.
REQ-024 in_data_o SHALL be 8'h00 whenever in_valid_o is low.
REQ-025 in_data_o SHALL stay stable while in_valid_o high and in_ready_i low.
REQ-026 Each accepted output byte SHALL increment rd_ptr and decrement line_len_o.
REQ-027 The edge accepting the last byte (line_len_o==1) SHALL return to FILL, wr_ptr=rd_ptr=0, line_len_o=0, idle counter 0.
REQ-028 out_valid_i in DRAIN SHALL be ignored; no byte is lost since out_ready_o is low.
REQ-029 A line of exactly DEPTH bytes ending in TERMINATOR SHALL drain once, DEPTH bytes, no extra.
REQ-030 Pointer arithmetic SHALL be modulo DEPTH; line_len_o SHALL never exceed DEPTH.

Reset
REQ-031 rst_i high SHALL immediately force state FILL, wr_ptr/rd_ptr/line_len_o/idle counter 0: out_ready_o=1, in_valid_o=0, in_data_o=8'h00, busy_o=0.
REQ-032 Reset mid-DRAIN SHALL discard buffered bytes; no partial output after release.
REQ-033 Buffer storage SHALL need no reset; content is undefined until written.

Verification
REQ-034 Send "ab1\r" (61 62 31 0D), in_ready_i=1 -> output 41 42 31 0D, in_valid_o rises 1 clock after 0D accepted, back to FILL.
REQ-035 UPPERCASE=0, send "z{\r" -> output 7A 7B 0D unchanged; 8'h60/8'h7B never modified with UPPERCASE=1.
REQ-036 DEPTH=4, send 5 bytes no terminator -> first 4 drained, out_ready_o low during drain, 5th byte accepted afterwards.
REQ-037 TIMEOUT=10, send 2 bytes then idle -> DRAIN entered exactly 10 idle clocks after last byte; no drain with zero bytes after 100 idle clocks.
REQ-038 Drain with in_ready_i toggling 1/0 per cycle -> in_data_o stable while stalled, all bytes in order, no duplicates.
REQ-039 Assert rst_i during DRAIN after 1 of 3 bytes -> outputs at reset values immediately, no remaining bytes emitted after release.
